// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, receiver state encoding and byte type.
// Kept separate so the matching transmitter can reuse the same timing and types.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEFAULT = 104;  // 12 MHz / 115200 baud

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } rx_state_e;

   typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte stream plus status flags between uart_rx and its consumer.
// uart_rx uses the master modport; the consumer uses the slave modport.
interface uart_rx_if;
   import uart_pkg::*;

   uart_byte_t out_data;
   logic       out_valid;
   logic       out_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      output out_data, out_valid, frame_err, overrun, busy,
      input  out_ready
   );

   modport slave (
      input  out_data, out_valid, frame_err, overrun, busy,
      output out_ready
   );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input that idles high.
// Both flops preset to 1 so reset never looks like a falling edge.
module uart_sync (
   input  logic clk_12p0,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   // NOTE: sequential state uses non-blocking assignments so the two flops form a real two-stage pipeline.
   always_ff @(posedge clk_12p0) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit, hands bytes over a valid/ready
// stream, and flags framing errors and dropped bytes with single-cycle pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic     clk_12p0,
   input  logic     rst,
   input  logic     rx_in,
   uart_rx_if.master bus
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

   logic             rx_s;
   rx_state_e        state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   uart_byte_t       shift_reg;
   uart_byte_t       out_data;
   logic             out_valid;
   logic             frame_err;
   logic             overrun;
   logic             byte_done;
   logic             stop_bad;

   uart_sync u_sync (
      .clk_12p0 (clk_12p0),
      .rst      (rst),
      .d        (rx_in),
      .q        (rx_s)
   );

   assign byte_done = (state == ST_STOP) && (cnt == CNT_LAST) &&  rx_s;
   assign stop_bad  = (state == ST_STOP) && (cnt == CNT_LAST) && !rx_s;

   always_ff @(posedge clk_12p0) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (!rx_s) state <= ST_START;
            end
            ST_START: begin
               // A start bit that is high again at its centre was a glitch.
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state   <= ST_DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt                <= '0;
                  shift_reg[bit_idx] <= rx_s;
                  if (bit_idx == 3'd7) state   <= ST_STOP;
                  else                 bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_WAIT_HIGH: begin
               // A held-low line (break) must go high before a new start is accepted.
               if (rx_s) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_12p0) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= 1'b0;
         if (byte_done) begin
            // A byte is dropped only if the previous one is still unconsumed.
            if (!out_valid || bus.out_ready) begin
               out_data  <= shift_reg;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign bus.out_data  = out_data;
   assign bus.out_valid = out_valid;
   assign bus.frame_err = frame_err;
   assign bus.overrun   = overrun;
   assign bus.busy      = (state != ST_IDLE);
endmodule
